// File: rtl/dbi_rx_phy.sv
// DBI Type B (8080) receive PHY: oversamples the bus on clk, decodes each
// WRX rising edge into a command or parameter byte and queues it in a FIFO.
module dbi_rx_phy #(
  parameter int DBI_IF_D_W = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dbi_csx_i,
  input  logic                  dbi_dcx_i,
  input  logic                  dbi_wrx_i,
  input  logic                  dbi_rdx_i,
  input  logic                  dbi_resx_i,
  input  logic [DBI_IF_D_W-1:0] dbi_d_i,
  input  logic                  rx_rdy_i,
  input  logic                  ovf_clr_i,
  output logic                  rx_vld_o,
  output logic                  rx_is_cmd_o,
  output logic [DBI_IF_D_W-1:0] rx_cmd_typ_o,
  output logic [DBI_IF_D_W-1:0] rx_dat_o,
  output logic [CNT_W-1:0]      rx_idx_o,
  output logic                  rx_end_o,
  output logic                  rx_hrst_o,
  output logic                  rx_ovf_o,
  output logic                  rx_rd_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic                  is_cmd;
    logic [DBI_IF_D_W-1:0] cmd;
    logic [DBI_IF_D_W-1:0] dat;
    logic [CNT_W-1:0]      idx;
  } rx_ent_t;

  logic                  csx_s1, csx_s2, dcx_s1, dcx_s2, wrx_s1, wrx_s2;
  logic                  rdx_s1, rdx_s2, resx_s1, resx_s2;
  logic [DBI_IF_D_W-1:0] d_s1, d_s2;
  logic                  wrx_p, rdx_p, csx_p;

  logic [DBI_IF_D_W-1:0] cur_cmd;
  logic [CNT_W-1:0]      idx;
  logic                  seen;

  rx_ent_t               mem [FIFO_DEPTH];
  rx_ent_t               new_ent, head;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  empty, full, push, pop, push_ok, ovf_set, rd_set;

  // Strobe/data synchronizers; idle-high strobes reset to 1 so no false edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {csx_s2, csx_s1}   <= 2'b11;
      {wrx_s2, wrx_s1}   <= 2'b11;
      {rdx_s2, rdx_s1}   <= 2'b11;
      {resx_s2, resx_s1} <= 2'b11;
      {dcx_s2, dcx_s1}   <= 2'b00;
      d_s1  <= '0;
      d_s2  <= '0;
      wrx_p <= 1'b1;
      rdx_p <= 1'b1;
      csx_p <= 1'b1;
    end else begin
      {csx_s2, csx_s1}   <= {csx_s1, dbi_csx_i};
      {wrx_s2, wrx_s1}   <= {wrx_s1, dbi_wrx_i};
      {rdx_s2, rdx_s1}   <= {rdx_s1, dbi_rdx_i};
      {resx_s2, resx_s1} <= {resx_s1, dbi_resx_i};
      {dcx_s2, dcx_s1}   <= {dcx_s1, dbi_dcx_i};
      d_s1  <= dbi_d_i;
      d_s2  <= d_s1;
      wrx_p <= wrx_s2;
      rdx_p <= rdx_s2;
      csx_p <= csx_s2;
    end
  end

  assign push     = wrx_s2 & ~wrx_p & ~csx_s2 & resx_s2;
  assign rx_end_o = csx_s2 & ~csx_p & seen & resx_s2;
  assign rd_set   = ~rdx_s2 & rdx_p & ~csx_s2;
  assign rx_hrst_o = ~resx_s2;

  always_comb begin
    new_ent.is_cmd = ~dcx_s2;
    new_ent.dat    = d_s2;
    new_ent.cmd    = dcx_s2 ? cur_cmd : d_s2;
    new_ent.idx    = dcx_s2 ? idx : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_cmd <= '0;
      idx     <= '0;
      seen    <= 1'b0;
    end else if (!resx_s2) begin
      cur_cmd <= '0;
      idx     <= '0;
      seen    <= 1'b0;
    end else if (push) begin
      seen <= 1'b1;
      if (!dcx_s2) begin
        cur_cmd <= d_s2;
        idx     <= '0;
      end else if (idx != {CNT_W{1'b1}}) begin
        idx <= idx + CNT_W'(1);
      end
    end else if (rx_end_o) begin
      seen <= 1'b0;
    end
  end

  // FIFO: extra pointer bit distinguishes full from empty
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rx_vld_o & rx_rdy_i;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (!resx_s2) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= new_ent;
  end

  // Head fields forced to zero when empty so reset values hold without clearing mem
  assign head         = mem[rd_ptr[AW-1:0]];
  assign rx_vld_o     = ~empty;
  assign rx_is_cmd_o  = rx_vld_o & head.is_cmd;
  assign rx_cmd_typ_o = rx_vld_o ? head.cmd : '0;
  assign rx_dat_o     = rx_vld_o ? head.dat : '0;
  assign rx_idx_o     = rx_vld_o ? head.idx : '0;

  // Sticky flags survive RESX; a same-cycle set beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ovf_o    <= 1'b0;
      rx_rd_err_o <= 1'b0;
    end else begin
      rx_ovf_o    <= ovf_set | (rx_ovf_o & ~ovf_clr_i);
      rx_rd_err_o <= rd_set | (rx_rd_err_o & ~ovf_clr_i);
    end
  end

endmodule

// File: tb/tb_dbi_rx_phy.sv
// Randomized bench for dbi_rx_phy against a transaction-level queue model.
module tb_dbi_rx_phy;
  localparam int W = 8, DEPTH = 8, CW = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic csx = 1'b1, dcx = 1'b0, wrx = 1'b1, rdx = 1'b1, resx = 1'b1;
  logic [W-1:0] d = '0;
  logic rdy = 1'b0, ovf_clr = 1'b0;
  logic rx_vld_o, rx_is_cmd_o, rx_end_o, rx_hrst_o, rx_ovf_o, rx_rd_err_o;
  logic [W-1:0] rx_cmd_typ_o, rx_dat_o;
  logic [CW-1:0] rx_idx_o;

  always #5 clk = ~clk;

  dbi_rx_phy #(.DBI_IF_D_W(W), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .dbi_csx_i(csx), .dbi_dcx_i(dcx), .dbi_wrx_i(wrx),
    .dbi_rdx_i(rdx), .dbi_resx_i(resx), .dbi_d_i(d), .rx_rdy_i(rdy), .ovf_clr_i(ovf_clr),
    .rx_vld_o(rx_vld_o), .rx_is_cmd_o(rx_is_cmd_o), .rx_cmd_typ_o(rx_cmd_typ_o),
    .rx_dat_o(rx_dat_o), .rx_idx_o(rx_idx_o), .rx_end_o(rx_end_o), .rx_hrst_o(rx_hrst_o),
    .rx_ovf_o(rx_ovf_o), .rx_rd_err_o(rx_rd_err_o)
  );

  typedef struct {
    bit       is_cmd;
    bit [7:0] cmd;
    bit [7:0] dat;
    int       idx;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   checks = 0, errors = 0;
  int   end_cnt = 0, hrst_cnt = 0, exp_end = 0;
  bit   mon_en = 0, rand_rdy = 0;
  bit [7:0] m_cmd;
  int   m_idx;
  bit   m_seen, m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // Observes output handshakes, end pulses and hardware-reset cycles
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_end_o) end_cnt++;
      if (rx_hrst_o) hrst_cnt++;
      if (mon_en && rx_vld_o && rdy) begin
        if (exp_q.size() == 0) chk("pop_unexpected", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          chk("head_is_cmd", rx_is_cmd_o, mon_e.is_cmd);
          chk("head_cmd", rx_cmd_typ_o, mon_e.cmd);
          chk("head_dat", rx_dat_o, mon_e.dat);
          chk("head_idx", rx_idx_o, mon_e.idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_cmd = 0; m_idx = 0; m_seen = 0;
  endtask

  // Reference rules: a command resets the index, a parameter inherits the command
  task automatic m_write(input bit dc, input bit [7:0] b, input bit force_acc);
    ent_t e;
    if (csx || !resx) return;
    if (!dc) begin
      m_cmd = b; m_idx = 0;
      e.is_cmd = 1; e.cmd = b; e.dat = b; e.idx = 0;
    end else begin
      e.is_cmd = 0; e.cmd = m_cmd; e.dat = b; e.idx = m_idx;
      if (m_idx < 65535) m_idx++;
    end
    m_seen = 1;
    if (exp_q.size() < DEPTH || force_acc) exp_q.push_back(e);
    else m_ovf = 1;
  endtask

  task automatic wr_rise(input bit dc, input bit [7:0] b, input bit force_acc);
    dcx = dc; d = b; wrx = 1'b0;
    repeat (3) tick();
    wrx = 1'b1;
    m_write(dc, b, force_acc);
  endtask

  task automatic wr(input bit dc, input bit [7:0] b);
    wr_rise(dc, b, 1'b0);
    repeat (3) tick();
  endtask

  task automatic csx_lo();
    csx = 1'b0;
    repeat (2) tick();
  endtask

  task automatic csx_hi();
    csx = 1'b1;
    if (m_seen) exp_end++;
    m_seen = 0;
    repeat (4) tick();
  endtask

  task automatic drain();
    rand_rdy = 0; rdy = 1'b1;
    repeat (24) tick();
    chk("drain_model_empty", exp_q.size(), 0);
    chk("drain_vld", rx_vld_o, 1'b0);
    rdy = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", rx_vld_o, 0);
    chk("rst_is_cmd", rx_is_cmd_o, 0);
    chk("rst_cmd", rx_cmd_typ_o, 0);
    chk("rst_dat", rx_dat_o, 0);
    chk("rst_idx", rx_idx_o, 0);
    chk("rst_end", rx_end_o, 0);
    chk("rst_ovf", rx_ovf_o, 0);
    chk("rst_rderr", rx_rd_err_o, 0);
    chk("rst_hrst", rx_hrst_o, 0);
    rst_n = 1'b1; m_reset(); m_ovf = 0; mon_en = 1;
    repeat (3) tick();

    // command + parameters, with first-byte latency
    csx_lo();
    wr_rise(0, 8'h2A, 0);
    tick(); chk("lat_e0", rx_vld_o, 0);
    tick(); chk("lat_e1", rx_vld_o, 0);
    tick(); chk("lat_e2", rx_vld_o, 1);
    rand_rdy = 1;
    wr(1, 8'h00); wr(1, 8'h10); wr(1, 8'h00); wr(1, 8'hEF);
    csx_hi();
    drain();
    chk("end_cmd_params", end_cnt, exp_end);

    // CSX gating
    for (int i = 0; i < 4; i++) wr(i[0], 8'hA0 + 8'(i));
    repeat (5) tick();
    chk("gate_vld", rx_vld_o, 0);
    chk("gate_end", end_cnt, exp_end);

    // overflow, clear, then full push with simultaneous pop
    csx_lo();
    for (int i = 0; i < 10; i++) wr(1, 8'h40 + 8'(i));
    chk("ovf_set", rx_ovf_o, m_ovf);
    chk("ovf_full_vld", rx_vld_o, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; m_ovf = 0;
    chk("ovf_clr", rx_ovf_o, m_ovf);
    wr_rise(1, 8'h77, 1);
    tick(); tick();
    rdy = 1'b1; tick(); rdy = 1'b0;
    tick(); tick();
    chk("ovf_pop_push", rx_ovf_o, m_ovf);
    drain();
    csx_hi();
    chk("end_ovf", end_cnt, exp_end);

    // hardware reset flush
    csx_lo();
    wr(0, 8'h11); wr(1, 8'h01); wr(1, 8'h02);
    chk("hrst_pre_vld", rx_vld_o, 1);
    hrst_cnt = 0; resx = 1'b0;
    tick(); chk("hrst_e0", rx_hrst_o, 0);
    tick(); chk("hrst_e1", rx_hrst_o, 1);
    repeat (3) tick();
    resx = 1'b1; m_reset();
    repeat (4) tick();
    chk("hrst_cycles", hrst_cnt, 5);
    chk("hrst_release", rx_hrst_o, 0);
    chk("hrst_flushed", rx_vld_o, 0);
    wr(1, 8'h99);
    drain();
    csx_hi();
    chk("end_hrst", end_cnt, exp_end);

    // back-to-back commands
    rand_rdy = 1;
    csx_lo();
    wr(0, 8'h2C); wr(1, 8'h01); wr(1, 8'h02); wr(1, 8'h03); wr(0, 8'h29);
    csx_hi();
    drain();
    chk("end_b2b", end_cnt, exp_end);

    // random transactions
    for (int t = 0; t < 20; t++) begin
      int n;
      rand_rdy = 1;
      csx_lo();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) wr(($urandom_range(0, 2) != 0), 8'($urandom));
      csx_hi();
    end
    drain();
    chk("end_random", end_cnt, exp_end);
    chk("ovf_random", rx_ovf_o, m_ovf);

    // read attempt
    csx_lo();
    chk("rderr_pre", rx_rd_err_o, 0);
    rdx = 1'b0; repeat (3) tick(); rdx = 1'b1; repeat (3) tick();
    chk("rderr_set", rx_rd_err_o, 1);
    chk("rderr_nodata", rx_vld_o, 0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("rderr_clr", rx_rd_err_o, 0);

    // async reset mid-byte
    wr(0, 8'h5A);
    rdx = 1'b0; repeat (3) tick(); rdx = 1'b1;
    dcx = 1'b1; d = 8'h55; wrx = 1'b0; repeat (3) tick(); wrx = 1'b1; tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", rx_vld_o, 0);
    chk("arst_is_cmd", rx_is_cmd_o, 0);
    chk("arst_cmd", rx_cmd_typ_o, 0);
    chk("arst_dat", rx_dat_o, 0);
    chk("arst_idx", rx_idx_o, 0);
    chk("arst_end", rx_end_o, 0);
    chk("arst_ovf", rx_ovf_o, 0);
    chk("arst_rderr", rx_rd_err_o, 0);
    chk("arst_hrst", rx_hrst_o, 0);
    csx = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) tick();
    chk("arst_no_end", end_cnt, exp_end);
    chk("arst_no_vld", rx_vld_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbi_rx_phy.md
# dbi_rx_phy

- Receive-side PHY for the MIPI DBI Type B (8080-style) parallel display bus, the counterpart of the DBI transmit PHY in the display TX controller.
- Oversamples the DBI strobes and data on the internal clock and decodes each WRX rising edge into a command byte or a parameter/pixel byte.
- Buffers decoded bytes in a small FIFO with a valid/ready output.
- Used as the display-side model in loopback verification, and as the front end of a future DBI-input bridge.

## Interface

Parameters:
- DBI_IF_D_W, 8, DBI data bus width.
- FIFO_DEPTH, 8, output FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, parameter-index counter width.

Ports:
- clk  in  1  internal clock.
- rst_n  in  1  asynchronous reset, active low.
- dbi_csx_i  in  1  chip select, active low, asynchronous to clk.
- dbi_dcx_i  in  1  0 = command byte, 1 = parameter/pixel byte.
- dbi_wrx_i  in  1  write strobe; data is latched on its rising edge.
- dbi_rdx_i  in  1  read strobe. Reads are not supported; a read attempt is only flagged.
- dbi_resx_i  in  1  display hardware reset, active low.
- dbi_d_i  in  DBI_IF_D_W  DBI data bus.
- rx_rdy_i  in  1  consumer ready.
- ovf_clr_i  in  1  clears the sticky error flags.
- rx_vld_o  out  1  FIFO head is valid.
- rx_is_cmd_o  out  1  FIFO head is a command byte.
- rx_cmd_typ_o  out  DBI_IF_D_W  command in effect for the FIFO head; for a command entry this equals its own byte.
- rx_dat_o  out  DBI_IF_D_W  received byte.
- rx_idx_o  out  CNT_W  parameter index within the current command; 0 for a command entry.
- rx_end_o  out  1  single-cycle pulse at transaction end.
- rx_hrst_o  out  1  synchronized RESX is low.
- rx_ovf_o  out  1  sticky flag: a byte was dropped because the FIFO was full.
- rx_rd_err_o  out  1  sticky flag: RDX fell while CSX was low.

## Operation

Input synchronization:
- csx, dcx, wrx, rdx, resx and d each pass through a 2-flop synchronizer (s1, s2).
- Reset values: csx/wrx/rdx/resx stages = 1; dcx/d stages = 0.
- Registered copies wrx_p and rdx_p of the s2 values provide edge detection. csx_p records the s2 CSX value and also has reset value 1.

Write event:
- A write event is s2 wrx = 1, wrx_p = 0, and s2 csx = 0. WRX edges while CSX is high are ignored.

Decoding a write event:
- s2 dcx = 0 (command):
  - cur_cmd is set to the byte.
  - idx is set to 0.
  - Pushed entry: {is_cmd=1, cmd=byte, dat=byte, idx=0}.
  - Sets the seen flag.
- s2 dcx = 1 (parameter/pixel):
  - Pushed entry: {is_cmd=0, cmd=cur_cmd, dat=byte, idx=idx}.
  - idx then increments, saturating at 2^CNT_W-1.
  - Sets the seen flag.
- A parameter byte arriving before any command since reset or flush carries cmd = 0.

Transaction end:
- rx_end_o pulses for one cycle when s2 csx rises from 0 to 1 and seen = 1. seen then clears.

FIFO:
- Pop occurs when rx_vld_o & rx_rdy_i.
- A push while full is dropped and sets rx_ovf_o, except when a pop happens in the same cycle; then the push is accepted.
- rx_vld_o is high whenever the FIFO is non-empty, and the head fields are stable while rx_rdy_i is low.

Read attempt:
- An s2 rdx falling edge with s2 csx = 0 sets rx_rd_err_o. No data is driven.

Hardware reset (s2 resx = 0):
- rx_hrst_o is 1.
- The FIFO is flushed, cur_cmd, idx and seen are cleared, and write events are ignored.
- rx_ovf_o and rx_rd_err_o are not cleared by RESX.

Sticky flag clearing:
- ovf_clr_i clears rx_ovf_o and rx_rd_err_o.
- If a set and a clear occur in the same cycle, the set wins.

## Timing

Output reset values (rst_n low):
- rx_vld_o = 0, rx_is_cmd_o = 0, rx_cmd_typ_o = 0, rx_dat_o = 0, rx_idx_o = 0.
- rx_end_o = 0, rx_ovf_o = 0, rx_rd_err_o = 0.
- rx_hrst_o = 0, because the synchronizer stages reset to 1.

Latency:
- Let edge 0 be the first clk edge that samples dbi_wrx_i = 1.
- The write event is decoded in the cycle after edge 1.
- With an empty FIFO, rx_vld_o rises after edge 2.
- rx_end_o asserts in the cycle after the second clk edge following the CSX rise.
- rx_hrst_o follows dbi_resx_i with a 2-cycle delay.

Input constraints on the bus:
- WRX low time and high time must each be at least 3 clk periods.
- dbi_d_i and dbi_dcx_i must be stable from 2 clk periods before to 3 clk periods after the WRX rising edge.
- CSX must stay low for at least 3 clk periods after the last WRX rising edge.
- Violating these constraints gives undefined bytes but must not hang the block.

Throughput:
- At most one push per clk. Sustained rate is one byte per 6 clk periods or slower.

Reset mid-transfer:
- Asserting rst_n or RESX discards any partially received transaction. No rx_end_o is generated for it.

## Test plan

- **Command + parameters:** CSX low, write cmd 0x2A, then params 0x00, 0x10, 0x00, 0xEF, then CSX high. Required: 5 entries — (cmd, 0x2A, idx 0), then (0x2A, 0x00, idx 0), (0x2A, 0x10, idx 1), (0x2A, 0x00, idx 2), (0x2A, 0xEF, idx 3). One rx_end_o pulse. rx_vld_o rises 3 edges after the first sampled WRX high.
- **CSX gating:** WRX toggles 4 times with CSX high. Required: no entries, no rx_end_o.
- **Overflow:** rx_rdy_i = 0, 10 parameter bytes with FIFO_DEPTH = 8. Required: 8 entries kept (first 8 bytes), rx_ovf_o = 1. ovf_clr_i pulse clears it. A push while full with rx_rdy_i = 1 in the same cycle is accepted with no overflow.
- **Hardware reset:** 3 bytes buffered, then RESX low for 5 clks. Required: rx_hrst_o high for 5 cycles after a 2-cycle delay, FIFO empty. A next parameter byte carries cmd 0 and idx 0.
- **Back-to-back commands:** 0x2C with 3 params, then 0x29 with none, inside one CSX window. Required: idx resets to 0 on 0x29, cmd fields are correct, one rx_end_o pulse.
- **Read attempt and async reset:** RDX pulse with CSX low sets rx_rd_err_o. rst_n asserted mid-byte: all outputs go to their reset values immediately.
